pc_sequencer: RTL and testbench
===============================

// Module: pc_sequencer
// PURPOSE
//  Next-PC controller for the 5-stage pipeline. Drives dirEntrada/enable of the PC register.
//  Arbitrates between sequential fetch, EX-stage branch redirect, ID-stage jump,
//  load-use stall and multi-cycle (mul/div) stall; emits IF/ID and ID/EX flush/enable.
//  Sits between the hazard unit, branch/jump logic and the PC register.
// PARAMETERS
//  ADDR_W       32     PC/target width
//  RESET_VECTOR 32'h0  first fetch address after reset
//  CNT_W        4      width of multi-cycle stall length/counter
// PORTS
//  clk             in   1       clock; state updates on posedge (PC register samples on negedge)
//  reset           in   1       asynchronous, active-high
//  pc_cur          in   ADDR_W  current PC (PC register output)
//  branch_taken    in   1       EX-stage branch resolved taken
//  branch_target   in   ADDR_W  branch destination
//  jump            in   1       ID-stage jump
//  jump_target     in   ADDR_W  jump destination
//  load_use_hazard in   1       one-cycle stall request from hazard unit
//  mc_stall_req    in   1       multi-cycle stall request (sampled in RUN only)
//  mc_stall_cycles in   CNT_W   stall length N
//  pc_next         out  ADDR_W  to PC register data input
//  pc_en           out  1       to PC register enable
//  ifid_en         out  1       IF/ID register enable
//  ifid_flush      out  1       IF/ID bubble insert
//  idex_flush      out  1       ID/EX bubble insert
//  busy            out  1       high while in MCSTALL
//  state_dbg       out  2       BOOT=0, RUN=1, MCSTALL=2
// BEHAVIOUR
//  - Outputs combinational from registered state + inputs; must settle within half a clk period.
//  - Reset asserted (any time, incl. mid-stall): state=BOOT, counter=0; pc_next=RESET_VECTOR,
//    pc_en=0, ifid_en=0, ifid_flush=1, idex_flush=1, busy=0.
//  - BOOT (one cycle after reset release): pc_next=RESET_VECTOR, pc_en=1, both flushes=1 -> RUN.
//  - RUN, priority branch_taken > jump > mc_stall_req(N>0) > load_use_hazard > sequential:
//    * branch: pc_next=branch_target, pc_en=1, ifid_flush=1, idex_flush=1.
//    * jump: pc_next=jump_target, pc_en=1, ifid_flush=1.
//    * mc stall N: pc_en=0, ifid_en=0, idex_flush=1; N=1 -> stay RUN; N>=2 -> counter=N-1, MCSTALL.
//      N=0 treated as no request (falls through to next priority).
//    * load-use: pc_en=0, ifid_en=0, idex_flush=1 for exactly that cycle; stays RUN.
//    * else pc_next=pc_cur+4 (mod 2^ADDR_W, 0xFFFFFFFC wraps to 0), pc_en=1, ifid_en=1.
//  - MCSTALL: pc_en=0, ifid_en=0, idex_flush=1, busy=1; counter-- each cycle; counter==1 -> RUN.
//    Total stall = N cycles. mc_stall_req/load_use ignored in MCSTALL.
//    branch_taken in MCSTALL aborts stall: redirect as in RUN, counter=0, -> RUN.
//  - Targets: bits [1:0] forced to 0 before driving pc_next.
//  - Default in every state: ifid_en=1, flushes=0, pc_en=1 unless stated above.
// CONFIGURATION
//  PC_SEQ_DELAY_SLOT_EN defined: one architectural delay slot; jump asserts no ifid_flush;
//    branch asserts ifid_flush only (instruction in ID is the slot, idex_flush=0).
//  Undefined: jump flushes IF/ID; branch flushes IF/ID and ID/EX (as above).
// TESTING
//  1 reset pulse, release -> BOOT cycle pc_next=0, pc_en=1, flushes=1; next cycle pc_cur=0 -> pc_next=4.
//  2 pc_cur=0x100, branch_taken=1, target=0x203, jump=1 same cycle -> pc_next=0x200, both flushes=1.
//  3 pc_cur=0x40, mc_stall_req=1, N=3 -> pc_en=0 for 3 cycles, busy=1 for cycles 2-3, then pc_next=0x44.
//  4 load_use_hazard=1 one cycle at pc_cur=0x20 -> pc_en=0, idex_flush=1, ifid_en=0; next cycle pc_next=0x24.
//  5 MCSTALL with N=8, reset asserted after 2 cycles -> immediate BOOT outputs, busy=0, counter=0.
//  6 pc_cur=0xFFFFFFFC sequential -> pc_next=0; with PC_SEQ_DELAY_SLOT_EN, jump -> ifid_flush=0.

Source files
------------

// File: rtl/pc_sequencer.sv
// Next-PC controller: picks the PC register input/enable and the IF/ID, ID/EX bubble controls.
// Optional build macro PC_SEQ_DELAY_SLOT_EN gives one architectural delay slot after branch/jump.
module pc_sequencer #(
  parameter int                ADDR_W       = 32,
  parameter logic [ADDR_W-1:0] RESET_VECTOR = '0,
  parameter int                CNT_W        = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] pc_cur,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_target,
  input  logic              jump,
  input  logic [ADDR_W-1:0] jump_target,
  input  logic              load_use_hazard,
  input  logic              mc_stall_req,
  input  logic [CNT_W-1:0]  mc_stall_cycles,
  output logic [ADDR_W-1:0] pc_next,
  output logic              pc_en,
  output logic              ifid_en,
  output logic              ifid_flush,
  output logic              idex_flush,
  output logic              busy,
  output logic [1:0]        state_dbg
);

  localparam logic [1:0] BOOT    = 2'd0;
  localparam logic [1:0] RUN     = 2'd1;
  localparam logic [1:0] MCSTALL = 2'd2;

`ifdef PC_SEQ_DELAY_SLOT_EN
  localparam logic DELAY_SLOT = 1'b1;
`else
  localparam logic DELAY_SLOT = 1'b0;
`endif

  logic [1:0]       state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;

  function automatic logic [ADDR_W-1:0] align_target(input logic [ADDR_W-1:0] t);
    return {t[ADDR_W-1:2], 2'b00};
  endfunction

  always_comb begin
    pc_next    = pc_cur + ADDR_W'(4);
    pc_en      = 1'b1;
    ifid_en    = 1'b1;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;
    busy       = 1'b0;
    state_nxt  = state;
    cnt_nxt    = cnt;
    case (state)
      BOOT: begin
        pc_next    = RESET_VECTOR;
        ifid_flush = 1'b1;
        idex_flush = 1'b1;
        state_nxt  = RUN;
      end
      RUN: begin
        if (branch_taken) begin
          pc_next    = align_target(branch_target);
          ifid_flush = 1'b1;
          idex_flush = ~DELAY_SLOT;
        end else if (jump) begin
          pc_next    = align_target(jump_target);
          ifid_flush = ~DELAY_SLOT;
        end else if (mc_stall_req && (mc_stall_cycles != '0)) begin
          // First stall cycle is spent here; MCSTALL covers the remaining N-1.
          pc_next    = pc_cur;
          pc_en      = 1'b0;
          ifid_en    = 1'b0;
          idex_flush = 1'b1;
          if (mc_stall_cycles > CNT_W'(1)) begin
            cnt_nxt   = mc_stall_cycles - CNT_W'(1);
            state_nxt = MCSTALL;
          end
        end else if (load_use_hazard) begin
          pc_next    = pc_cur;
          pc_en      = 1'b0;
          ifid_en    = 1'b0;
          idex_flush = 1'b1;
        end
      end
      MCSTALL: begin
        busy = 1'b1;
        if (branch_taken) begin
          pc_next    = align_target(branch_target);
          ifid_flush = 1'b1;
          idex_flush = ~DELAY_SLOT;
          cnt_nxt    = '0;
          state_nxt  = RUN;
        end else begin
          pc_next    = pc_cur;
          pc_en      = 1'b0;
          ifid_en    = 1'b0;
          idex_flush = 1'b1;
          cnt_nxt    = cnt - CNT_W'(1);
          if (cnt <= CNT_W'(1)) begin
            cnt_nxt   = '0;
            state_nxt = RUN;
          end
        end
      end
      default: state_nxt = BOOT;
    endcase
    // Reset overrides outputs immediately, not just at the next edge.
    if (reset) begin
      pc_next    = RESET_VECTOR;
      pc_en      = 1'b0;
      ifid_en    = 1'b0;
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
      busy       = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= BOOT;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  assign state_dbg = state;

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed scenarios then random traffic against a cycle-level model.
module tb_pc_sequencer;

`ifdef PC_SEQ_DELAY_SLOT_EN
  localparam bit DS = 1'b1;
`else
  localparam bit DS = 1'b0;
`endif
  localparam logic [31:0] RV = 32'h0;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc_cur, branch_target, jump_target;
  logic        branch_taken, jump, load_use_hazard, mc_stall_req;
  logic [3:0]  mc_stall_cycles;
  logic [31:0] pc_next;
  logic        pc_en, ifid_en, ifid_flush, idex_flush, busy;
  logic [1:0]  state_dbg;

  int checks = 0;
  int errors = 0;

  // Model state: boot cycle pending, and stall cycles still owed after the current one.
  bit m_boot = 1'b1;
  int m_stall = 0;

  always #5 clk = ~clk;

  pc_sequencer dut (
    .clk(clk), .reset(reset), .pc_cur(pc_cur),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .jump(jump), .jump_target(jump_target),
    .load_use_hazard(load_use_hazard), .mc_stall_req(mc_stall_req),
    .mc_stall_cycles(mc_stall_cycles),
    .pc_next(pc_next), .pc_en(pc_en), .ifid_en(ifid_en),
    .ifid_flush(ifid_flush), .idex_flush(idex_flush),
    .busy(busy), .state_dbg(state_dbg)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    reset = 0; branch_taken = 0; jump = 0; load_use_hazard = 0; mc_stall_req = 0;
    mc_stall_cycles = 0; branch_target = 0; jump_target = 0;
  endtask

  // Evaluate one cycle: inputs already driven; check outputs mid-cycle, then advance.
  task automatic step(input string tag);
    logic [31:0] e_pc;
    logic e_en, e_ifen, e_iff, e_idf, e_busy;
    logic [1:0] e_st;
    bit nb;
    int ns;
    #3;
    nb = m_boot; ns = m_stall;
    e_pc = pc_cur + 32'd4; e_en = 1; e_ifen = 1; e_iff = 0; e_idf = 0; e_busy = 0; e_st = 2'd1;
    if (reset) begin
      e_pc = RV; e_en = 0; e_ifen = 0; e_iff = 1; e_idf = 1; e_st = 2'd0; nb = 1; ns = 0;
    end else if (m_boot) begin
      e_pc = RV; e_iff = 1; e_idf = 1; e_st = 2'd0; nb = 0;
    end else if (m_stall > 0) begin
      e_st = 2'd2; e_busy = 1;
      if (branch_taken) begin
        e_pc = branch_target & 32'hFFFF_FFFC; e_iff = 1; e_idf = !DS; ns = 0;
      end else begin
        e_en = 0; e_ifen = 0; e_idf = 1; ns = m_stall - 1;
      end
    end else if (branch_taken) begin
      e_pc = branch_target & 32'hFFFF_FFFC; e_iff = 1; e_idf = !DS;
    end else if (jump) begin
      e_pc = jump_target & 32'hFFFF_FFFC; e_iff = !DS;
    end else if (mc_stall_req && mc_stall_cycles != 0) begin
      e_en = 0; e_ifen = 0; e_idf = 1; ns = int'(mc_stall_cycles) - 1;
    end else if (load_use_hazard) begin
      e_en = 0; e_ifen = 0; e_idf = 1;
    end
    chk({tag, ".pc_en"}, 32'(pc_en), 32'(e_en));
    chk({tag, ".ifid_en"}, 32'(ifid_en), 32'(e_ifen));
    chk({tag, ".ifid_flush"}, 32'(ifid_flush), 32'(e_iff));
    chk({tag, ".idex_flush"}, 32'(idex_flush), 32'(e_idf));
    chk({tag, ".busy"}, 32'(busy), 32'(e_busy));
    chk({tag, ".state"}, 32'(state_dbg), 32'(e_st));
    // pc_next is only meaningful when the PC register will load it.
    if (e_en || reset) chk({tag, ".pc_next"}, pc_next, e_pc);
    @(posedge clk);
    m_boot = nb; m_stall = ns;
    #1;
  endtask

  initial begin
    idle(); pc_cur = 0; reset = 1;
    step("t1_reset");
    reset = 0;
    step("t1_boot");
    pc_cur = 32'h0;
    step("t1_seq");

    pc_cur = 32'h100; branch_taken = 1; branch_target = 32'h203; jump = 1; jump_target = 32'h500;
    step("t2_branch_over_jump");
    idle(); pc_cur = 32'h300; jump = 1; jump_target = 32'h77;
    step("t2_jump");
    idle();

    pc_cur = 32'h40; mc_stall_req = 1; mc_stall_cycles = 4'd3;
    step("t3_mc1");
    mc_stall_req = 0; load_use_hazard = 1;
    step("t3_mc2");
    step("t3_mc3");
    load_use_hazard = 0;
    step("t3_resume");

    mc_stall_req = 1; mc_stall_cycles = 4'd1; pc_cur = 32'h80;
    step("t3_n1");
    mc_stall_cycles = 4'd0;
    step("t3_n0");
    idle();

    pc_cur = 32'h20; load_use_hazard = 1;
    step("t4_lu");
    load_use_hazard = 0;
    step("t4_after");

    pc_cur = 32'h60; mc_stall_req = 1; mc_stall_cycles = 4'd8;
    step("t5_mc1");
    mc_stall_req = 0;
    step("t5_mc2");
    reset = 1;
    step("t5_reset");
    reset = 0;
    step("t5_boot");
    step("t5_run");

    pc_cur = 32'h10; mc_stall_req = 1; mc_stall_cycles = 4'd5;
    step("abort_mc1");
    mc_stall_req = 0;
    step("abort_mc2");
    branch_taken = 1; branch_target = 32'h1234_5679;
    step("abort_branch");
    idle();
    step("abort_run");

    pc_cur = 32'hFFFF_FFFC;
    step("t6_wrap");
    jump = 1; jump_target = 32'hABCD_EF02;
    step("t6_jump");
    idle();

    for (int i = 0; i < 400; i++) begin
      reset           = ($urandom_range(0, 49) == 0);
      branch_taken    = ($urandom_range(0, 7) == 0);
      jump            = ($urandom_range(0, 5) == 0);
      mc_stall_req    = ($urandom_range(0, 7) == 0);
      mc_stall_cycles = 4'($urandom_range(0, 15));
      load_use_hazard = ($urandom_range(0, 4) == 0);
      branch_target   = $urandom;
      jump_target     = $urandom;
      pc_cur          = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFFC : ($urandom & 32'hFFFF_FFFC);
      step($sformatf("rnd%0d", i));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
